tour_cmd: RTL and testbench

- Sits between the tour solver (TourLogic) and the command processor (cmd_proc) inside KnightsTour.
- In UART mode it passes host commands straight through to cmd_proc.
- On start_tour it takes control and steps through the NUM_MOVES solved moves. Each one-hot knight move becomes two cmd_proc commands: a vertical leg first, then a horizontal leg with fanfare.
- It also generates the response byte returned to RemoteComm.

---
 rtl/tour_pkg.sv | 38 +++
 rtl/move_decode.sv | 37 +++
 rtl/tour_cmd.sv | 100 ++++++++++
 tb/tb_tour_cmd.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared types and encodings for the knight's-tour command sequencer.
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        VWAIT,
        HORZ,
        HWAIT
    } tour_state_t;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_MOVE_FF = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_INT = 8'h5A;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] heading;
        logic [3:0] squares;
    } cmd_t;

    function automatic cmd_t make_cmd(input logic [3:0] op, input logic [7:0] hdg,
                                      input logic [1:0] sq);
        cmd_t c;
        c.opcode  = op;
        c.heading = hdg;
        c.squares = {2'b00, sq};
        return c;
    endfunction

endpackage

// File: rtl/move_decode.sv
// Splits a one-hot knight move into a vertical leg command and a horizontal
// leg command (with fanfare). Malformed moves decode as bit0.
module move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);

    logic       dx_pos;
    logic       dy_pos;
    logic [1:0] dx_mag;
    logic [1:0] dy_mag;

    always_comb begin
        // bit0 (+1,+2) doubles as the fallback for zero or multi-hot moves
        dx_pos = 1'b1;
        dx_mag = 2'd1;
        dy_pos = 1'b1;
        dy_mag = 2'd2;
        case (move)
            8'h02: begin dx_pos = 1'b0; dx_mag = 2'd1; dy_pos = 1'b1; dy_mag = 2'd2; end
            8'h04: begin dx_pos = 1'b0; dx_mag = 2'd2; dy_pos = 1'b1; dy_mag = 2'd1; end
            8'h08: begin dx_pos = 1'b0; dx_mag = 2'd2; dy_pos = 1'b0; dy_mag = 2'd1; end
            8'h10: begin dx_pos = 1'b0; dx_mag = 2'd1; dy_pos = 1'b0; dy_mag = 2'd2; end
            8'h20: begin dx_pos = 1'b1; dx_mag = 2'd1; dy_pos = 1'b0; dy_mag = 2'd2; end
            8'h40: begin dx_pos = 1'b1; dx_mag = 2'd2; dy_pos = 1'b0; dy_mag = 2'd1; end
            8'h80: begin dx_pos = 1'b1; dx_mag = 2'd2; dy_pos = 1'b1; dy_mag = 2'd1; end
            default: ;
        endcase
    end

    assign vert_cmd = make_cmd(OP_MOVE,    dy_pos ? HDG_N : HDG_S, dy_mag);
    assign horz_cmd = make_cmd(OP_MOVE_FF, dx_pos ? HDG_E : HDG_W, dx_mag);

endmodule

// File: rtl/tour_cmd.sv
// Muxes UART commands to cmd_proc when idle; during a tour, replays each
// solved knight move as a vertical leg followed by a horizontal leg.
module tour_cmd
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    tour_state_t      state_q, state_d;
    logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
    logic [15:0]      vert_cmd;
    logic [15:0]      horz_cmd;
    logic             last_mv;

    move_decode u_move_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    assign last_mv = (mv_indx_q == LAST_IDX);
    assign mv_indx = mv_indx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    // Outputs decode straight from state so cmd_rdy rises one clock after
    // start_tour or the preceding send_resp.
    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        cmd       = cmd_UART;
        cmd_rdy   = cmd_rdy_UART;
        resp      = RESP_ACK;
        case (state_q)
            IDLE: begin
                if (start_tour) begin
                    state_d   = VERT;
                    mv_indx_d = '0;
                end
            end
            VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
                resp    = RESP_INT;
                if (clr_cmd_rdy) state_d = VWAIT;
            end
            VWAIT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b0;
                resp    = RESP_INT;
                if (send_resp) state_d = HORZ;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                resp    = RESP_INT;
                if (clr_cmd_rdy) state_d = HWAIT;
            end
            HWAIT: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b0;
                resp    = last_mv ? RESP_ACK : RESP_INT;
                if (send_resp) begin
                    if (last_mv) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = VERT;
                        mv_indx_d = mv_indx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Randomized and directed bench for tour_cmd against a move-replay model.
module tb_tour_cmd;

    localparam int NUM_MOVES = 24;
    localparam int IDX_W     = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_tour = 1'b0;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic [15:0]      cmd_UART = 16'h0000;
    logic             cmd_rdy_UART = 1'b0;
    logic             clr_cmd_rdy = 1'b0;
    logic             send_resp = 1'b0;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic [7:0]       resp;

    logic [7:0] tbl [NUM_MOVES];

    int dchk = 0, dfail = 0;
    int mchk = 0, mfail = 0;
    int rise_cnt = 0;
    logic prev_rdy = 1'b0;

    always #5 clk = ~clk;

    // TourLogic stand-in: combinational lookup of the solved move
    assign move = (int'(mv_indx) < NUM_MOVES) ? tbl[mv_indx] : 8'h00;

    tour_cmd #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .resp         (resp)
    );

    // Expected leg command from the (dx,dy) table of knight moves
    function automatic logic [15:0] exp_leg(input logic [7:0] mv, input bit horiz);
        int dx [8];
        int dy [8];
        int b;
        int d;
        dx = '{1, -1, -2, -2, -1, 1, 2, 2};
        dy = '{2, 2, 1, -1, -2, -2, -1, 1};
        b = 0;
        if ($countones(mv) == 1)
            for (int i = 0; i < 8; i++) if (mv[i]) b = i;
        d = horiz ? dx[b] : dy[b];
        if (horiz)
            return {4'h3, (d > 0) ? 8'hBF : 8'h3F, 4'((d < 0) ? -d : d)};
        else
            return {4'h2, (d > 0) ? 8'h00 : 8'h7F, 4'((d < 0) ? -d : d)};
    endfunction

    // Model: tour position as (index, leg, command outstanding)
    bit m_active, m_leg, m_pend;
    int m_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0; m_idx <= 0; m_leg <= 1'b0; m_pend <= 1'b0;
        end else if (!m_active) begin
            if (start_tour) begin
                m_active <= 1'b1; m_idx <= 0; m_leg <= 1'b0; m_pend <= 1'b1;
            end
        end else if (m_pend) begin
            if (clr_cmd_rdy) m_pend <= 1'b0;
        end else if (send_resp) begin
            if (!m_leg) begin
                m_leg <= 1'b1; m_pend <= 1'b1;
            end else if (m_idx == NUM_MOVES - 1) begin
                m_active <= 1'b0;
            end else begin
                m_idx <= m_idx + 1; m_leg <= 1'b0; m_pend <= 1'b1;
            end
        end
    end

    logic [15:0] e_cmd;
    logic        e_rdy;
    logic [7:0]  e_resp;

    always_comb begin
        e_cmd  = cmd_UART;
        e_rdy  = cmd_rdy_UART;
        e_resp = 8'hA5;
        if (m_active) begin
            e_cmd  = exp_leg(tbl[m_idx], m_leg);
            e_rdy  = m_pend;
            e_resp = (m_leg && !m_pend && m_idx == NUM_MOVES - 1) ? 8'hA5 : 8'h5A;
        end
    end

    always @(negedge clk) begin
        if (cmd !== e_cmd)
            $display("FAIL model_cmd t=%0t got %h want %h", $time, cmd, e_cmd);
        if (cmd_rdy !== e_rdy)
            $display("FAIL model_cmd_rdy t=%0t got %b want %b", $time, cmd_rdy, e_rdy);
        if (resp !== e_resp)
            $display("FAIL model_resp t=%0t got %h want %h", $time, resp, e_resp);
        if (int'(mv_indx) != m_idx)
            $display("FAIL model_mv_indx t=%0t got %0d want %0d", $time, mv_indx, m_idx);
        mchk  <= mchk + 4;
        mfail <= mfail + int'(cmd !== e_cmd) + int'(cmd_rdy !== e_rdy)
                       + int'(resp !== e_resp) + int'(int'(mv_indx) != m_idx);
        if (cmd_rdy && !prev_rdy && m_active) rise_cnt <= rise_cnt + 1;
        prev_rdy <= cmd_rdy;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        dchk++;
        if (got !== want) begin
            dfail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_rdy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            dchk++;
            dfail++;
            $display("FAIL wait_rdy: cmd_rdy timeout got 0 want 1");
        end
    endtask

    task automatic idle_tick(input bit noise);
        if (noise && ($urandom_range(0, 2) == 0)) begin
            start_tour   = 1'b1;
            cmd_rdy_UART = 1'b1;
        end
        cmd_UART = 16'($urandom);
        tick();
        start_tour   = 1'b0;
        cmd_rdy_UART = 1'b0;
    endtask

    // cmd_proc stand-in: consume each leg, then acknowledge it
    task automatic run_legs(input int n, input bit last_send, input bit chk_idx, input bit noise);
        bit ok;
        for (int m = 0; m < n; m++) begin
            wait_rdy(ok);
            if (!ok) return;
            if (chk_idx) check("leg_mv_indx", 32'(mv_indx), 32'(m / 2));
            repeat ($urandom_range(0, 2)) idle_tick(noise);
            clr_cmd_rdy = 1'b1;
            tick();
            clr_cmd_rdy = 1'b0;
            repeat ($urandom_range(0, 2)) idle_tick(noise);
            if (m < n - 1 || last_send) begin
                send_resp = 1'b1;
                tick();
                send_resp = 1'b0;
            end
        end
    endtask

    task automatic sweep(input logic [7:0] mv, input logic [15:0] ev, input logic [15:0] eh);
        do_reset();
        tbl[0] = mv;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        check("sweep_vert", 32'(cmd), 32'(ev));
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("sweep_horz", 32'(cmd), 32'(eh));
    endtask

    task automatic rand_table();
        logic [7:0] one;
        int r;
        one = 8'h01;
        for (int i = 0; i < NUM_MOVES; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      tbl[i] = 8'h00;
            else if (r == 1) tbl[i] = 8'h81;
            else             tbl[i] = one << $urandom_range(0, 7);
        end
    endtask

    initial begin
        int rise0;
        for (int i = 0; i < NUM_MOVES; i++) tbl[i] = 8'h01;
        do_reset();

        // UART passthrough after reset
        cmd_UART = 16'h2000;
        cmd_rdy_UART = 1'b1;
        #1;
        check("rst_cmd", 32'(cmd), 32'h2000);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'h1);
        check("rst_resp", 32'(resp), 32'hA5);
        check("rst_mv_indx", 32'(mv_indx), 32'h0);
        cmd_rdy_UART = 1'b0;
        tick();

        // Directed two-move sequence with a simultaneous clr/send
        tbl[0] = 8'h01;
        tbl[1] = 8'h80;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        check("d_vert_cmd", 32'(cmd), 32'h2002);
        check("d_vert_rdy", 32'(cmd_rdy), 32'h1);
        check("d_vert_resp", 32'(resp), 32'h5A);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        check("d_vwait_rdy", 32'(cmd_rdy), 32'h0);
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("d_horz_cmd", 32'(cmd), 32'h3BF1);
        check("d_horz_rdy", 32'(cmd_rdy), 32'h1);
        check("d_horz_resp", 32'(resp), 32'h5A);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        check("d_hwait_resp", 32'(resp), 32'h5A);
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("d_next_idx", 32'(mv_indx), 32'h1);
        check("d_next_cmd", 32'(cmd), 32'h2001);
        clr_cmd_rdy = 1'b1;
        send_resp = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        check("d_both_rdy", 32'(cmd_rdy), 32'h0);
        tick();
        tick();
        check("d_both_hold_rdy", 32'(cmd_rdy), 32'h0);
        check("d_both_hold_cmd", 32'(cmd), 32'h2001);
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("d_both_horz", 32'(cmd), 32'h3BF2);

        sweep(8'h08, 16'h27F1, 16'h33F2);
        sweep(8'h40, 16'h27F1, 16'h3BF2);
        sweep(8'h00, 16'h2002, 16'h3BF1);
        sweep(8'h24, 16'h2002, 16'h3BF1);

        // Full randomized tour with noise pulses mid-tour
        do_reset();
        rand_table();
        rise0 = rise_cnt;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        run_legs(2 * NUM_MOVES, 1'b0, 1'b1, 1'b1);
        check("final_resp", 32'(resp), 32'hA5);
        check("final_idx", 32'(mv_indx), 32'(NUM_MOVES - 1));
        check("final_rdy", 32'(cmd_rdy), 32'h0);
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("rise_count", 32'(rise_cnt - rise0), 32'(2 * NUM_MOVES));
        cmd_UART = 16'h2123;
        cmd_rdy_UART = 1'b1;
        #1;
        check("post_uart_cmd", 32'(cmd), 32'h2123);
        check("post_uart_rdy", 32'(cmd_rdy), 32'h1);
        check("post_uart_resp", 32'(resp), 32'hA5);
        tick();
        cmd_rdy_UART = 1'b0;

        // Abort from HWAIT at index 10
        do_reset();
        rand_table();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        run_legs(22, 1'b0, 1'b0, 1'b0);
        check("abort_pre_idx", 32'(mv_indx), 32'd10);
        start_tour = 1'b1;
        cmd_rdy_UART = 1'b1;
        tick();
        start_tour = 1'b0;
        cmd_rdy_UART = 1'b0;
        check("noise_idx", 32'(mv_indx), 32'd10);
        check("noise_rdy", 32'(cmd_rdy), 32'h0);
        check("noise_resp", 32'(resp), 32'h5A);
        cmd_UART = 16'h2BEE;
        rst = 1'b1;
        #1;
        check("abort_rdy", 32'(cmd_rdy), 32'h0);
        check("abort_idx", 32'(mv_indx), 32'h0);
        check("abort_resp", 32'(resp), 32'hA5);
        check("abort_cmd", 32'(cmd), 32'h2BEE);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("abort_idle_rdy", 32'(cmd_rdy), 32'h0);

        // Second randomized full tour
        rand_table();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        run_legs(2 * NUM_MOVES, 1'b1, 1'b1, 1'b1);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", dchk + mchk, dfail + mfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
